// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared entry and state types for the instruction prefetch queue
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        error;
    } FetchQEntry;

    typedef enum logic {FQ_RUN, FQ_ERR_HOLD} FetchQState;

    localparam int unsigned FQ_ENTRY_W = $bits(FetchQEntry);
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetchq_fifo: synchronous FIFO with flush; accepts push when full if a pop happens the same cycle
module fetchq_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CAP;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between imem and fetch, flushed on redirect.
// Define FETCHQ_BYPASS_EN to forward a response straight to fetch when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_error,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_error,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    FetchQState    state;
    logic [CW-1:0] inflight, discard, occ, tag_count;
    logic          held, can_issue, acc, tag_push, resp_take, push, pop;
    logic          d_full, d_empty, t_full, t_empty;
    logic [31:0]   tag_pc;
    FetchQEntry    resp_e, head;

    // held keeps an unaccepted request stable even if issue conditions drop
    assign can_issue     = state == FQ_RUN && ({1'b0, occ} + {1'b0, inflight}) < LIMIT;
    assign mem_req_valid = rst && (held || can_issue);
    assign acc           = mem_req_valid && mem_req_ready;
    assign tag_push      = acc && !redirect_valid;
    assign resp_take     = mem_resp_valid && !redirect_valid && discard == '0;
    assign resp_e        = '{data: mem_resp_data, pc: tag_pc, error: mem_resp_error};
    assign pop           = inst_ready && !d_empty;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass     = rst && resp_take && d_empty;
    assign inst_valid = !d_empty || bypass;
    assign {inst_data, inst_pc, inst_error} = bypass ? resp_e : head;
    assign push       = resp_take && !(bypass && inst_ready);
`else
    assign inst_valid = !d_empty;
    assign {inst_data, inst_pc, inst_error} = head;
    assign push       = resp_take;
`endif

    fetchq_fifo #(.WIDTH(FQ_ENTRY_W), .DEPTH(DEPTH)) u_data (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
        .din(resp_e), .dout(head), .full(d_full), .empty(d_empty), .count(occ)
    );

    fetchq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .rst(rst), .push(tag_push), .pop(resp_take), .flush(redirect_valid),
        .din(mem_req_addr), .dout(tag_pc), .full(t_full), .empty(t_empty), .count(tag_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FQ_RUN;
            inflight     <= '0;
            discard      <= '0;
            held         <= 1'b0;
            mem_req_addr <= RESET_PC;
        end else if (redirect_valid) begin
            // every response still owed, including one accepted now, must be dropped
            state        <= FQ_RUN;
            inflight     <= '0;
            discard      <= discard + inflight + CW'(acc) - CW'(mem_resp_valid);
            held         <= 1'b0;
            mem_req_addr <= redirect_pc & ~32'h3;
        end else begin
            if (resp_take && mem_resp_error) state <= FQ_ERR_HOLD;
            inflight <= inflight + CW'(acc) - CW'(resp_take);
            discard  <= discard - CW'(mem_resp_valid && discard != '0);
            held     <= mem_req_valid && !mem_req_ready;
            if (acc) mem_req_addr <= mem_req_addr + 32'd4;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        {1'b0, inflight} <= LIMIT && {1'b0, discard} <= LIMIT && tag_count == inflight);
    assert property (@(posedge clk) disable iff (!rst)
        !(push && d_full && !pop) && !(tag_push && t_full) && !(resp_take && t_empty));
endmodule
